gaussian_kernel_gen: RTL and testbench
======================================

Name: gaussian_kernel_gen

Overview:
- Synthesizable, runtime-configurable successor to the real-valued gaussian_kernel.
- Builds an odd N x N Gaussian smoothing kernel as a binomial (Pascal) approximation, with sigma^2 = (N-1)/4.
- Streams unsigned fixed-point coefficients, row-major, over a valid/ready handshake into the convolution stage's coefficient buffer.
- Normalisation is exact (power of two): every kernel's coefficients sum to exactly 2^FRAC_W.

Parameters:
- MAX_SIZE, 7: largest supported kernel dimension; odd, 3..9.
- FRAC_W, 16: coefficient width, unsigned Q0.FRAC_W. Must satisfy FRAC_W >= 2*(MAX_SIZE-1); elaboration-time assertion.
- SZ_W, $clog2(MAX_SIZE+1): width of size and index fields.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request kernel generation; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE.
- size_cfg  in  SZ_W  kernel dimension N.
- busy  out  1  high in BUILD or STREAM.
- cfg_err  out  1  one-cycle pulse: start was rejected for an invalid size.
- coef_valid  out  1  coefficient present.
- coef_ready  in  1  consumer accepts.
- coef_data  out  FRAC_W  coefficient value.
- coef_row  out  SZ_W  row index i.
- coef_col  out  SZ_W  column index j.
- coef_last  out  1  marks element [N-1][N-1].
- done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - Binomial array cleared.
- States: IDLE, BUILD, STREAM.
- IDLE:
  - On start=1 with a valid size_cfg (odd, 3 <= N <= MAX_SIZE): latch N and n=N-1; bin[0]=1, others 0; go to BUILD.
  - On start=1 with an invalid size_cfg: pulse cfg_err for one cycle next cycle; stay in IDLE.
- BUILD:
  - Each cycle: bin[k] <= bin[k] + bin[k-1] for all k in 1..n, updated in parallel.
  - After exactly n cycles bin[k] = C(n,k); go to STREAM with row=col=0.
  - Binomial entries are n bits wide.
- STREAM:
  - coef_data = (bin[row]*bin[col]) << (FRAC_W-2n). The product is exact; no rounding.
  - coef_valid is high throughout STREAM.
- Latency: first coef_valid is asserted n+1 cycles after the edge that samples start.
- Handshake:
  - A transfer occurs when coef_valid && coef_ready.
  - While coef_valid && !coef_ready, coef_data, coef_row, coef_col and coef_last hold stable.
  - Order is row-major: col increments; at col=N-1, col wraps to 0 and row increments.
  - coef_last = (row==N-1 && col==N-1).
- Completion: a transfer with coef_last=1 causes, next cycle, state=IDLE, coef_valid=0 and a one-cycle done pulse.
- Throughput: one coefficient per cycle when coef_ready is held high; N*N transfers per kernel.
- busy = (state != IDLE).
- start while busy is ignored and does not raise cfg_err.
- abort:
  - Has priority over start and over a same-cycle transfer.
  - Next cycle: IDLE, coef_valid=0, no done pulse.
  - In IDLE it has no effect, and a same-cycle start is ignored.
- size_cfg is sampled only at accepted start; later changes have no effect on the kernel in progress.
- Asynchronous reset mid-BUILD or mid-STREAM returns to IDLE immediately; no done, no further valid.

Decomposition:
- Package gaussian_pkg holds:
  - state enum kgen_state_t {IDLE, BUILD, STREAM};
  - function is_valid_size(N, MAX_SIZE);
  - localparam helpers for SZ_W and BIN_W = MAX_SIZE-1.
- One sub-module, binomial_row_gen:
  - Holds the Pascal array.
  - Controls: clear, step.
  - Output: bin[MAX_SIZE] as a packed array.
- Top level holds the FSM, counters, multiplier/shift and handshake.

Test Plan:
- size_cfg=5, coef_ready=1:
  - first valid 5 cycles after start;
  - [0][0]=256, [0][1]=1024, [0][2]=1536, [2][2]=9216;
  - symmetric; 25 transfers; sum=65536; done pulse one cycle after coef_last.
- size_cfg=3:
  - [0][0]=4096, [0][1]=8192, [1][1]=16384; sum=65536.
- size_cfg=7:
  - [3][3]=6400, [0][0]=16; sum=65536; 49 transfers.
- Backpressure on size 5: toggle coef_ready pseudo-randomly.
  - Data and indices stay stable while stalled.
  - Same 25 values in order; exactly one done.
- size_cfg=4, then 1, then 9 (MAX_SIZE=7):
  - each gives a one-cycle cfg_err; busy stays 0; no coef_valid.
- Interrupts:
  - reset=0 mid-STREAM (at transfer 10): all outputs 0 immediately, no done.
  - A restart with size 5 produces the full correct kernel.
  - abort at transfer 3 behaves the same, one cycle later.

Source files
------------

// File: rtl/gaussian_pkg.sv
// Shared types and sizing helpers for the binomial Gaussian kernel generator.
package gaussian_pkg;

  typedef enum logic [1:0] {IDLE, BUILD, STREAM} kgen_state_t;

  localparam int DEF_MAX_SIZE = 7;
  localparam int DEF_FRAC_W   = 16;

  function automatic int sz_width(input int max_size);
    return $clog2(max_size + 1);
  endfunction

  // C(n,k) for n <= MAX_SIZE-1 never exceeds 2^(MAX_SIZE-1)-1 in the supported range.
  function automatic int bin_width(input int max_size);
    return max_size - 1;
  endfunction

  function automatic logic is_valid_size(input int n, input int max_size);
    return n[0] && (n >= 3) && (n <= max_size);
  endfunction

endpackage

// File: rtl/binomial_row_gen.sv
// Pascal-triangle row builder: one row per step, entries 1..n updated in parallel.
module binomial_row_gen
  import gaussian_pkg::*;
#(
  parameter int MAX_SIZE = DEF_MAX_SIZE,
  parameter int SZ_W     = sz_width(MAX_SIZE),
  parameter int BIN_W    = bin_width(MAX_SIZE)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              step,
  input  logic [SZ_W-1:0]                   n,
  output logic [MAX_SIZE-1:0][BIN_W-1:0]    bin
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin <= '0;
    end else if (clear) begin
      bin    <= '0;
      bin[0] <= BIN_W'(1);
    end else if (step) begin
      // Non-blocking reads of bin[k-1] see the previous row, so all k update together.
      for (int k = 1; k < MAX_SIZE; k++) begin
        if (k <= int'(n)) bin[k] <= bin[k] + bin[k-1];
      end
    end
  end

endmodule

// File: rtl/gaussian_kernel_gen.sv
// Streams an odd NxN binomial Gaussian kernel, row-major, as Q0.FRAC_W coefficients
// whose sum is exactly 2^FRAC_W.
module gaussian_kernel_gen
  import gaussian_pkg::*;
#(
  parameter int MAX_SIZE = DEF_MAX_SIZE,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int SZ_W     = sz_width(MAX_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [SZ_W-1:0]   size_cfg,
  output logic              busy,
  output logic              cfg_err,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [FRAC_W-1:0] coef_data,
  output logic [SZ_W-1:0]   coef_row,
  output logic [SZ_W-1:0]   coef_col,
  output logic              coef_last,
  output logic              done
);

  localparam int BIN_W = bin_width(MAX_SIZE);
  localparam int SH_W  = $clog2(FRAC_W + 1);

  if (FRAC_W < 2 * (MAX_SIZE - 1)) begin : g_bad_frac
    $error("gaussian_kernel_gen: FRAC_W must be >= 2*(MAX_SIZE-1)");
  end
  if (MAX_SIZE < 3 || MAX_SIZE > 9 || MAX_SIZE % 2 == 0) begin : g_bad_size
    $error("gaussian_kernel_gen: MAX_SIZE must be odd, 3..9");
  end

  kgen_state_t                     state;
  logic [SZ_W-1:0]                 n_r, bld_cnt, row, col;
  logic [MAX_SIZE-1:0][BIN_W-1:0]  bin;
  logic                            ok_size, clear, step, xfer, at_last;
  logic [2*BIN_W-1:0]              prod;
  logic [SH_W-1:0]                 shamt;
  logic [FRAC_W-1:0]               scaled;

  assign ok_size = is_valid_size(int'(size_cfg), MAX_SIZE);
  assign clear   = (state == IDLE) && start && !abort && ok_size;
  assign step    = (state == BUILD) && (bld_cnt != n_r);
  assign xfer    = coef_valid && coef_ready;
  assign at_last = (row == n_r) && (col == n_r);

  binomial_row_gen #(.MAX_SIZE(MAX_SIZE), .SZ_W(SZ_W), .BIN_W(BIN_W)) u_bin (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .step  (step),
    .n     (n_r),
    .bin   (bin)
  );

  // C(n,i)*C(n,j) sums to 4^n over the kernel, so a left shift by FRAC_W-2n normalises exactly.
  assign prod   = (2*BIN_W)'(bin[row]) * (2*BIN_W)'(bin[col]);
  assign shamt  = SH_W'(FRAC_W - 2 * int'(n_r));
  assign scaled = FRAC_W'(prod) << shamt;

  assign busy      = (state != IDLE);
  assign coef_data = coef_valid ? scaled : '0;
  assign coef_row  = row;
  assign coef_col  = col;
  assign coef_last = coef_valid && at_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      n_r        <= '0;
      bld_cnt    <= '0;
      row        <= '0;
      col        <= '0;
      coef_valid <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (abort && state != IDLE) begin
        state      <= IDLE;
        coef_valid <= 1'b0;
        row        <= '0;
        col        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              if (ok_size) begin
                n_r     <= size_cfg - SZ_W'(1);
                bld_cnt <= '0;
                state   <= BUILD;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          BUILD: begin
            // One settle cycle after the n-th step before presenting data.
            if (bld_cnt == n_r) begin
              state      <= STREAM;
              coef_valid <= 1'b1;
              row        <= '0;
              col        <= '0;
            end else begin
              bld_cnt <= bld_cnt + SZ_W'(1);
            end
          end
          STREAM: begin
            if (xfer) begin
              if (at_last) begin
                state      <= IDLE;
                coef_valid <= 1'b0;
                done       <= 1'b1;
                row        <= '0;
                col        <= '0;
              end else if (col == n_r) begin
                col <= '0;
                row <= row + SZ_W'(1);
              end else begin
                col <= col + SZ_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gaussian_kernel_gen.sv
// Randomised self-checking bench for gaussian_kernel_gen against a binomial-coefficient model.
module tb_gaussian_kernel_gen;

  localparam int MAX_SIZE = 7;
  localparam int FRAC_W   = 16;
  localparam int SZ_W     = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, abort, coef_ready;
  logic [SZ_W-1:0]   size_cfg;
  logic              busy, cfg_err, coef_valid, coef_last, done;
  logic [FRAC_W-1:0] coef_data;
  logic [SZ_W-1:0]   coef_row, coef_col;

  gaussian_kernel_gen #(.MAX_SIZE(MAX_SIZE), .FRAC_W(FRAC_W), .SZ_W(SZ_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .size_cfg   (size_cfg),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .coef_row   (coef_row),
    .coef_col   (coef_col),
    .coef_last  (coef_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_err = 0;
  longint obs [9][9];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic longint model(input int sz, input int i, input int j);
    int n = sz - 1;
    return (binom(n, i) * binom(n, j)) << (FRAC_W - 2 * n);
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // abort_at / rst_at < 0 disable the interrupt; noise drives start/size_cfg randomly while busy.
  task automatic run_kernel(input int sz, input bit bp, input int abort_at, input int rst_at,
                            input bit noise);
    int     lat = 0;
    int     idx = 0;
    int     guard = 0;
    longint sum = 0;
    @(negedge clk);
    size_cfg = SZ_W'(sz);
    start    = 1'b1;
    cyc();
    start = 1'b0;
    if (noise) size_cfg = SZ_W'($urandom);
    while (!coef_valid && lat < 50) begin
      chk("busy_build", busy, 1);
      cyc();
      lat++;
    end
    chk("latency", lat, sz);
    while (idx < sz * sz && guard < 4000) begin
      guard++;
      if (idx == rst_at) begin
        reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", coef_valid, 0);
        chk("rst_data", coef_data, 0);
        chk("rst_last", coef_last, 0);
        chk("rst_done", done, 0);
        chk("rst_row", coef_row, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
          cyc();
          chk("post_rst_valid", coef_valid, 0);
          chk("post_rst_done", done, 0);
        end
        return;
      end
      chk("valid", coef_valid, 1);
      chk("row", coef_row, idx / sz);
      chk("col", coef_col, idx % sz);
      chk("last", coef_last, idx == sz * sz - 1);
      chk("data", coef_data, model(sz, idx / sz, idx % sz));
      chk("done_early", done, 0);
      chk("cfg_err_busy", cfg_err, 0);
      coef_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        size_cfg = SZ_W'($urandom);
      end
      if (idx == abort_at) begin
        abort      = 1'b1;
        coef_ready = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_valid", coef_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_data", coef_data, 0);
        cyc();
        chk("abort_done2", done, 0);
        chk("abort_valid2", coef_valid, 0);
        return;
      end
      if (coef_ready) begin
        obs[idx / sz][idx % sz] = longint'(coef_data);
        sum += longint'(coef_data);
        idx++;
      end
      cyc();
    end
    start      = 1'b0;
    coef_ready = 1'b0;
    chk("timeout", guard < 4000, 1);
    chk("done", done, 1);
    chk("end_valid", coef_valid, 0);
    chk("end_busy", busy, 0);
    chk("sum", sum, 64'd1 << FRAC_W);
    cyc();
    chk("done_once", done, 0);
  endtask

  task automatic bad_size(input int sz);
    @(negedge clk);
    size_cfg = SZ_W'(sz);
    start    = 1'b1;
    cyc();
    start = 1'b0;
    chk("cfg_err", cfg_err, 1);
    chk("bad_busy", busy, 0);
    chk("bad_valid", coef_valid, 0);
    cyc();
    chk("cfg_err_pulse", cfg_err, 0);
    chk("bad_busy2", busy, 0);
    chk("bad_valid2", coef_valid, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; coef_ready = 1'b0; size_cfg = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", coef_valid, 0);
    chk("reset_data", coef_data, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg_err", cfg_err, 0);
    chk("reset_last", coef_last, 0);
    reset = 1'b1;
    cyc();

    run_kernel(5, 0, -1, -1, 0);
    chk("k5_00", obs[0][0], 256);
    chk("k5_01", obs[0][1], 1024);
    chk("k5_02", obs[0][2], 1536);
    chk("k5_22", obs[2][2], 9216);
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++) chk("k5_sym", obs[i][j], obs[j][i]);

    run_kernel(3, 0, -1, -1, 0);
    chk("k3_00", obs[0][0], 4096);
    chk("k3_01", obs[0][1], 8192);
    chk("k3_11", obs[1][1], 16384);

    run_kernel(7, 0, -1, -1, 0);
    chk("k7_33", obs[3][3], 6400);
    chk("k7_00", obs[0][0], 16);

    run_kernel(5, 1, -1, -1, 0);

    for (int r = 0; r < 4; r++)
      run_kernel(2 * $urandom_range(1, 3) + 1, 1'($urandom_range(0, 1)), -1, -1, 1);

    // 9 does not fit a 3-bit size field; the unrepresentable/even/small values are covered instead.
    bad_size(4);
    bad_size(1);
    bad_size(0);
    bad_size(6);

    // abort in IDLE suppresses a same-cycle start, valid or not.
    @(negedge clk);
    size_cfg = 3'd5; start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_cfg_err", cfg_err, 0);

    run_kernel(5, 0, -1, 10, 0);
    run_kernel(5, 0, -1, -1, 0);
    run_kernel(5, 0, 3, -1, 0);
    run_kernel(5, 1, -1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
